// File: rtl/accumulator_ctrl.sv
// rtl/accumulator_ctrl.sv - accumulator bank sequencer: K-pass accumulate then row drain
//
// Purpose:
//   Steers accumulator_bank addr/wr_en/acc_mode while a tiled matmul streams
//   one partial-sum row per psum_valid. Pass 0 overwrites, later passes
//   accumulate. After the last pass every row is drained to the consumer
//   under a valid/ready handshake. Then done pulses once.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           one-cycle job start, only honoured in IDLE
//   cfg_seq_len     rows per pass (1..2^ADDR_WIDTH), latched on start
//   cfg_k_tiles     number of K passes (>=1), latched on start
//   psum_valid      one psum row presented this cycle
//   acc_addr        bank address
//   acc_wr_en       bank write enable
//   acc_mode        bank mode, 0 overwrite / 1 accumulate
//   drain_valid     bank read data for drain_row is valid
//   drain_ready     consumer accepts the drained row
//   drain_row       index of the row being drained
//   busy            job in progress (state != IDLE)
//   done            one-cycle pulse after the last row is accepted
//   cfg_err         one-cycle pulse when start is rejected for bad config
//   perf_stall      (ACC_CTRL_PERF_EN only) saturating stall-cycle counter
//
// Optional feature macro: ACC_CTRL_PERF_EN

module accumulator_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int KT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_seq_len,
  input  logic [KT_WIDTH-1:0]   cfg_k_tiles,
  input  logic                  psum_valid,
  output logic [ADDR_WIDTH-1:0] acc_addr,
  output logic                  acc_wr_en,
  output logic                  acc_mode,
  output logic                  drain_valid,
  input  logic                  drain_ready,
  output logic [ADDR_WIDTH-1:0] drain_row,
  output logic                  busy,
  output logic                  done,
`ifdef ACC_CTRL_PERF_EN
  output logic                  cfg_err,
  output logic [31:0]           perf_stall
`else
  output logic                  cfg_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   MAX_ROWS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   SEQ_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [KT_WIDTH-1:0]   KT_ONE   = KT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ROW_ONE  = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [KT_WIDTH-1:0]   kt_cnt_q, kt_cnt_d;
  logic [ADDR_WIDTH:0]   seq_len_q, seq_len_d;
  logic [KT_WIDTH-1:0]   k_tiles_q, k_tiles_d;
  logic                  cfg_err_q, cfg_err_d;

  logic cfg_bad;
  logic start_ok;
  logic last_row;
  logic last_kt;
  logic accept;

  assign cfg_bad  = (cfg_seq_len == '0) || (cfg_seq_len > MAX_ROWS) || (cfg_k_tiles == '0);
  assign start_ok = (state_q == S_IDLE) && start && !cfg_bad;
  // Compare in ADDR_WIDTH+1 bits so a 2^ADDR_WIDTH row pass ends at row 255, not 0
  assign last_row = ({1'b0, row_cnt_q} == (seq_len_q - SEQ_ONE));
  assign last_kt  = (kt_cnt_q == (k_tiles_q - KT_ONE));
  assign accept   = (state_q == S_DRAIN) && drain_ready;

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      kt_cnt_q  <= '0;
      seq_len_q <= '0;
      k_tiles_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      kt_cnt_q  <= kt_cnt_d;
      seq_len_q <= seq_len_d;
      k_tiles_q <= k_tiles_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_ACCUM;
      S_ACCUM: if (psum_valid && last_row && last_kt) state_d = S_DRAIN;
      S_DRAIN: if (accept && last_row) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter and config next values
  always_comb begin
    row_cnt_d = row_cnt_q;
    kt_cnt_d  = kt_cnt_q;
    seq_len_d = seq_len_q;
    k_tiles_d = k_tiles_q;
    cfg_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            seq_len_d = cfg_seq_len;
            k_tiles_d = cfg_k_tiles;
            row_cnt_d = '0;
            kt_cnt_d  = '0;
          end
        end
      end
      S_ACCUM: begin
        if (psum_valid) begin
          // Row wrap also covers the hand-off to DRAIN, which starts at row 0
          if (last_row) begin
            row_cnt_d = '0;
            kt_cnt_d  = kt_cnt_q + KT_ONE;
          end else begin
            row_cnt_d = row_cnt_q + ROW_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (accept) row_cnt_d = last_row ? '0 : row_cnt_q + ROW_ONE;
      end
      default: begin
        row_cnt_d = '0;
        kt_cnt_d  = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    acc_addr    = '0;
    acc_wr_en   = 1'b0;
    acc_mode    = 1'b0;
    drain_valid = 1'b0;
    drain_row   = '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    cfg_err     = cfg_err_q;
    case (state_q)
      S_ACCUM: begin
        acc_addr  = row_cnt_q;
        acc_wr_en = psum_valid;
        acc_mode  = (kt_cnt_q != '0);
      end
      S_DRAIN: begin
        // Bank read is asynchronous, so data for row_cnt_q is valid this cycle
        acc_addr    = row_cnt_q;
        drain_row   = row_cnt_q;
        drain_valid = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ACC_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_stall_q <= '0;
    else     perf_stall_q <= perf_stall_d;
  end

  always_comb begin
    perf_stall_d = perf_stall_q;
    if (start_ok) begin
      perf_stall_d = '0;
    end else if (((state_q == S_ACCUM) && !psum_valid) ||
                 ((state_q == S_DRAIN) && !drain_ready)) begin
      if (perf_stall_q != 32'hFFFF_FFFF) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_accumulator_ctrl.sv
// tb/tb_accumulator_ctrl.sv - directed self-checking bench for accumulator_ctrl

module tb_accumulator_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] cfg_seq_len;
  logic [7:0] cfg_k_tiles;
  logic       psum_valid;
  logic [7:0] acc_addr;
  logic       acc_wr_en;
  logic       acc_mode;
  logic       drain_valid;
  logic       drain_ready;
  logic [7:0] drain_row;
  logic       busy;
  logic       done;
  logic       cfg_err;

  accumulator_ctrl #(.ADDR_WIDTH(8), .KT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_seq_len(cfg_seq_len), .cfg_k_tiles(cfg_k_tiles),
    .psum_valid(psum_valid),
    .acc_addr(acc_addr), .acc_wr_en(acc_wr_en), .acc_mode(acc_mode),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_row(drain_row),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side bank and job model
  int bank [256];
  int seq_m, kt_m, kind_m, cval_m;
  int exp_wr_row, exp_pass, exp_drow;
  int n_wr, n_ovr, n_acc, n_drained, n_done;
  bit prev_done, hold_prev;
  int hold_row;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"},   acc_addr, 0);
    chk({tag, "_wr_en"},  acc_wr_en, 0);
    chk({tag, "_mode"},   acc_mode, 0);
    chk({tag, "_dvalid"}, drain_valid, 0);
    chk({tag, "_drow"},   drain_row, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_cfgerr"}, cfg_err, 0);
  endtask

  // Monitor on the falling edge: inputs settle at posedge+1
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done) chk("busy_after_done", busy, 0);
      prev_done = done;
      if (done) n_done++;
      if (hold_prev) begin
        chk("drain_hold_row", drain_row, hold_row);
        chk("drain_hold_valid", drain_valid, 1);
      end
      hold_prev = drain_valid && !drain_ready;
      hold_row  = drain_row;
      if (acc_wr_en) begin
        chk("wr_addr", acc_addr, exp_wr_row);
        chk("wr_mode", acc_mode, (exp_pass != 0));
        n_wr++;
        if (acc_mode) n_acc++; else n_ovr++;
        if (acc_mode) bank[acc_addr] = bank[acc_addr] + (kind_m != 0 ? exp_wr_row : cval_m);
        else          bank[acc_addr] = (kind_m != 0 ? exp_wr_row : cval_m);
        exp_wr_row++;
        if (exp_wr_row == seq_m) begin
          exp_wr_row = 0;
          exp_pass++;
        end
      end
      if (drain_valid && drain_ready) begin
        chk("drain_row", drain_row, exp_drow);
        chk("drain_addr", acc_addr, exp_drow);
        chk("drain_data", bank[drain_row], (kind_m != 0 ? exp_drow : cval_m) * kt_m);
        exp_drow++;
        n_drained++;
      end
    end
  end

  task automatic begin_job(input int seq, input int kt, input int kind, input int cval);
    seq_m = seq; kt_m = kt; kind_m = kind; cval_m = cval;
    exp_wr_row = 0; exp_pass = 0; exp_drow = 0;
    n_wr = 0; n_ovr = 0; n_acc = 0; n_drained = 0; n_done = 0;
    prev_done = 0; hold_prev = 0;
    cfg_seq_len = 9'(seq);
    cfg_k_tiles = 8'(kt);
    start       = 1'b1;
    psum_valid  = 1'b1;   // ignored while IDLE
    drain_ready = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_job(input int seq, input int kt, input int kind, input int cval,
                         input bit gap, input bit stall, input bit extra);
    int c;
    begin_job(seq, kt, kind, cval);
    c = 0;
    while (n_done == 0 && c < 3000) begin
      psum_valid  = gap ? (c % 2 == 0) : 1'b1;
      drain_ready = stall ? (c % 3 != 2) : 1'b1;
      start       = extra && (c == 50 || c == 650);
      cfg_seq_len = extra ? 9'd4 : 9'(seq);
      cfg_k_tiles = extra ? 8'd1 : 8'(kt);
      tick();
      c++;
    end
    chk("done_seen", (n_done != 0), 1);
    start = 1'b0; psum_valid = 1'b0; drain_ready = 1'b1;
    tick();
    tick();
    chk("done_count", n_done, 1);
    chk("writes_total", n_wr, seq * kt);
    chk("writes_overwrite", n_ovr, seq);
    chk("writes_accum", n_acc, seq * (kt - 1));
    chk("rows_drained", n_drained, seq);
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; cfg_seq_len = '0; cfg_k_tiles = '0;
    psum_valid = 1'b0; drain_ready = 1'b0;
    seq_m = 1; kt_m = 1; kind_m = 0; cval_m = 0;
    exp_wr_row = 0; exp_pass = 0; exp_drow = 0;
    n_wr = 0; n_ovr = 0; n_acc = 0; n_drained = 0; n_done = 0;
    prev_done = 0; hold_prev = 0; hold_row = 0;
    foreach (bank[i]) bank[i] = 0;
    tick(); tick(); tick();
    check_zero("reset");
    rst = 1'b0;
    psum_valid = 1'b1;   // ignored in IDLE
    drain_ready = 1'b1;
    tick();
    check_zero("idle");

    // 1: 197 rows x 3 passes of 5 -> 15
    run_job(197, 3, 0, 5, 1'b0, 1'b0, 1'b0);
    // 2: 256 rows, 1 pass, value = row index
    run_job(256, 1, 1, 0, 1'b0, 1'b0, 1'b0);
    // 3: gappy psum_valid and stalling drain_ready
    run_job(197, 3, 0, 5, 1'b1, 1'b1, 1'b0);

    // 4: rejected configs
    for (int t = 0; t < 3; t++) begin
      cfg_seq_len = (t == 0) ? 9'd0 : (t == 1) ? 9'd257 : 9'd197;
      cfg_k_tiles = (t == 2) ? 8'd0 : 8'd1;
      start = 1'b1; psum_valid = 1'b1;
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_err_busy", busy, 0);
      chk("cfg_err_wr_en", acc_wr_en, 0);
      tick();
      chk("cfg_err_clear", cfg_err, 0);
      chk("cfg_err_busy2", busy, 0);
    end
    psum_valid = 1'b0;

    // 5: reset mid-ACCUM at row 100 of tile 1, then a short job
    begin_job(197, 3, 0, 5);
    c = 0;
    while (!(exp_pass == 1 && exp_wr_row == 100) && c < 1000) begin
      psum_valid = 1'b1;
      tick();
      c++;
    end
    chk("reached_row100", (exp_pass == 1 && exp_wr_row == 100), 1);
    #2 rst = 1'b1;
    #1 check_zero("abort");
    tick();
    tick();
    rst = 1'b0;
    psum_valid = 1'b0;
    tick();
    check_zero("post_abort");
    run_job(4, 1, 0, 7, 1'b0, 1'b0, 1'b0);

    // 6: restart pulses mid-job (ACCUM and DRAIN), psum_valid in IDLE/DRAIN
    run_job(197, 3, 0, 5, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
